icache_ctrl: RTL and testbench

- Miss-handling controller sitting between the fetch stage and the 128-line x 64-bit direct-mapped instruction cache memory.
- Splits the fetch address into tag and index, and drives the cache memory read port.
- Returns hit data to fetch; on a miss, issues a single outstanding load to main memory.
- Matches the memory response tag and generates the cache write-port fill, forwarding fill data to fetch in the same cycle.

---
 rtl/icache_ctrl.sv | 137 +++++++++++++
 tb/tb_icache_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// Instruction-cache miss controller: zero-latency hit path, one outstanding
// memory load per miss, tag-matched fill with same-cycle forwarding to fetch.
module icache_ctrl #(
    parameter int TAG_W     = 22,
    parameter int IDX_W     = 7,
    parameter int MEM_TAG_W = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 proc2Icache_req,
    input  logic [63:0]          proc2Icache_addr,
    input  logic [63:0]          cachemem_data,
    input  logic                 cachemem_valid,
    input  logic [MEM_TAG_W-1:0] Imem2proc_response,
    input  logic [63:0]          Imem2proc_data,
    input  logic [MEM_TAG_W-1:0] Imem2proc_tag,
    output logic [63:0]          Icache_data_out,
    output logic                 Icache_valid_out,
    output logic [1:0]           proc2Imem_command,
    output logic [63:0]          proc2Imem_addr,
    output logic [IDX_W-1:0]     rd_idx,
    output logic [TAG_W-1:0]     rd_tag,
    output logic                 wr_en,
    output logic [IDX_W-1:0]     wr_idx,
    output logic [TAG_W-1:0]     wr_tag,
    output logic [63:0]          wr_data
);

    localparam int LINE_W = TAG_W + IDX_W;
    localparam int PAD_W  = 64 - LINE_W - 3;
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Cache line number of a byte address (tag concatenated with index).
    function automatic logic [LINE_W-1:0] line_of(input logic [63:0] addr);
        line_of = addr[LINE_W+2:3];
    endfunction

    state_t                 state_r, state_nxt_s;
    logic [TAG_W-1:0]       miss_tag_r, miss_tag_nxt_s;
    logic [IDX_W-1:0]       miss_idx_r, miss_idx_nxt_s;
    logic [MEM_TAG_W-1:0]   mem_tag_r, mem_tag_nxt_s;
    logic [LINE_W-1:0]      line_s;
    logic                   on_miss_line_s;
    logic                   tag_match_s;
    logic                   unused_s;

    assign line_s         = line_of(proc2Icache_addr);
    assign on_miss_line_s = proc2Icache_req && (line_s == {miss_tag_r, miss_idx_r});
    // A zero tag means "no data this cycle", so it can never match.
    assign tag_match_s    = (state_r == ST_WAIT) && (Imem2proc_tag != {MEM_TAG_W{1'b0}})
                            && (Imem2proc_tag == mem_tag_r);

    assign rd_idx         = line_s[IDX_W-1:0];
    assign rd_tag         = line_s[LINE_W-1:IDX_W];
    assign wr_idx         = miss_idx_r;
    assign wr_tag         = miss_tag_r;
    assign wr_data        = Imem2proc_data;
    assign proc2Imem_addr = {{PAD_W{1'b0}}, miss_tag_r, miss_idx_r, 3'b000};
    assign unused_s       = ^{proc2Icache_addr[63:LINE_W+3], proc2Icache_addr[2:0]};

    // Next-state, miss-register updates and combinational outputs.
    always_comb begin
        state_nxt_s       = state_r;
        miss_tag_nxt_s    = miss_tag_r;
        miss_idx_nxt_s    = miss_idx_r;
        mem_tag_nxt_s     = mem_tag_r;
        proc2Imem_command = BUS_NONE;
        wr_en             = 1'b0;
        Icache_valid_out  = proc2Icache_req && cachemem_valid;
        Icache_data_out   = cachemem_data;
        if (reset) begin
            state_nxt_s    = ST_IDLE;
            miss_tag_nxt_s = {TAG_W{1'b0}};
            miss_idx_nxt_s = {IDX_W{1'b0}};
            mem_tag_nxt_s  = {MEM_TAG_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (proc2Icache_req && !cachemem_valid) begin
                        state_nxt_s    = ST_REQ;
                        miss_tag_nxt_s = line_s[LINE_W-1:IDX_W];
                        miss_idx_nxt_s = line_s[IDX_W-1:0];
                    end else begin
                        state_nxt_s    = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // Fetch redirected away from the missing line: drop it unissued.
                    if (!on_miss_line_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        proc2Imem_command = BUS_LOAD;
                        if (Imem2proc_response != {MEM_TAG_W{1'b0}}) begin
                            mem_tag_nxt_s = Imem2proc_response;
                            state_nxt_s   = ST_WAIT;
                        end else begin
                            state_nxt_s   = ST_REQ;
                        end
                    end
                end
                ST_WAIT: begin
                    if (tag_match_s) begin
                        wr_en       = 1'b1;
                        state_nxt_s = ST_IDLE;
                        if (on_miss_line_s) begin
                            Icache_valid_out = 1'b1;
                            Icache_data_out  = Imem2proc_data;
                        end else begin
                            Icache_valid_out = proc2Icache_req && cachemem_valid;
                        end
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and miss-bookkeeping registers.
    always_ff @(posedge clock) begin
        state_r    <= state_nxt_s;
        miss_tag_r <= miss_tag_nxt_s;
        miss_idx_r <= miss_idx_nxt_s;
        mem_tag_r  <= mem_tag_nxt_s;
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed, table-driven bench for icache_ctrl with hand-written sequences for
// reset-during-request and a bounded wait for the memory load.
module tb_icache_ctrl;

    logic        clock;
    logic        reset;
    logic        proc2Icache_req;
    logic [63:0] proc2Icache_addr;
    logic [63:0] cachemem_data;
    logic        cachemem_valid;
    logic [3:0]  Imem2proc_response;
    logic [63:0] Imem2proc_data;
    logic [3:0]  Imem2proc_tag;
    logic [63:0] Icache_data_out;
    logic        Icache_valid_out;
    logic [1:0]  proc2Imem_command;
    logic [63:0] proc2Imem_addr;
    logic [6:0]  rd_idx;
    logic [21:0] rd_tag;
    logic        wr_en;
    logic [6:0]  wr_idx;
    logic [21:0] wr_tag;
    logic [63:0] wr_data;

    icache_ctrl dut (
        .clock              (clock),
        .reset              (reset),
        .proc2Icache_req    (proc2Icache_req),
        .proc2Icache_addr   (proc2Icache_addr),
        .cachemem_data      (cachemem_data),
        .cachemem_valid     (cachemem_valid),
        .Imem2proc_response (Imem2proc_response),
        .Imem2proc_data     (Imem2proc_data),
        .Imem2proc_tag      (Imem2proc_tag),
        .Icache_data_out    (Icache_data_out),
        .Icache_valid_out   (Icache_valid_out),
        .proc2Imem_command  (proc2Imem_command),
        .proc2Imem_addr     (proc2Imem_addr),
        .rd_idx             (rd_idx),
        .rd_tag             (rd_tag),
        .wr_en              (wr_en),
        .wr_idx             (wr_idx),
        .wr_tag             (wr_tag),
        .wr_data            (wr_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        req;
        logic [31:0] addr;
        logic        cv;
        logic [63:0] cd;
        logic [3:0]  resp;
        logic [63:0] md;
        logic [3:0]  mt;
        logic        e_v;
        logic [63:0] e_d;
        logic [1:0]  e_cmd;
        logic [63:0] e_pa;
        logic        chk_pa;
        logic        e_we;
        logic [6:0]  e_wi;
        logic [21:0] e_wt;
    } vec_t;

    vec_t tv[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic rst, input logic req, input logic [31:0] addr,
                                input logic cv, input logic [63:0] cd, input logic [3:0] resp,
                                input logic [63:0] md, input logic [3:0] mt, input logic e_v,
                                input logic [63:0] e_d, input logic [1:0] e_cmd,
                                input logic [63:0] e_pa, input logic chk_pa, input logic e_we,
                                input logic [6:0] e_wi, input logic [21:0] e_wt);
        vec_t v;
        v.rst = rst; v.req = req; v.addr = addr; v.cv = cv; v.cd = cd; v.resp = resp;
        v.md = md; v.mt = mt; v.e_v = e_v; v.e_d = e_d; v.e_cmd = e_cmd; v.e_pa = e_pa;
        v.chk_pa = chk_pa; v.e_we = e_we; v.e_wi = e_wi; v.e_wt = e_wt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic req, input logic [31:0] addr,
                         input logic cv, input logic [63:0] cd, input logic [3:0] resp,
                         input logic [63:0] md, input logic [3:0] mt);
        reset = rst; proc2Icache_req = req; proc2Icache_addr = {32'h0000_0000, addr};
        cachemem_valid = cv; cachemem_data = cd; Imem2proc_response = resp;
        Imem2proc_data = md; Imem2proc_tag = mt;
    endtask

    task automatic check_vec(input vec_t v, input string id);
        n_vec++;
        chk({id, " valid_out"}, {63'd0, Icache_valid_out}, {63'd0, v.e_v});
        chk({id, " data_out"}, Icache_data_out, v.e_d);
        chk({id, " command"}, {62'd0, proc2Imem_command}, {62'd0, v.e_cmd});
        chk({id, " wr_en"}, {63'd0, wr_en}, {63'd0, v.e_we});
        chk({id, " rd_idx"}, {57'd0, rd_idx}, {57'd0, v.addr[9:3]});
        chk({id, " rd_tag"}, {42'd0, rd_tag}, {42'd0, v.addr[31:10]});
        if (v.chk_pa || v.e_cmd == 2'd1) begin
            chk({id, " mem_addr"}, proc2Imem_addr, v.e_pa);
        end
        if (v.e_we) begin
            chk({id, " wr_idx"}, {57'd0, wr_idx}, {57'd0, v.e_wi});
            chk({id, " wr_tag"}, {42'd0, wr_tag}, {42'd0, v.e_wt});
            chk({id, " wr_data"}, wr_data, v.md);
        end
    endtask

    initial begin
        vec_t h;
        logic found;
        // rst req addr cv cd resp md mt | v d cmd pa chk_pa we wi wt
        // reset, hit on 0x1008
        tv.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 4'h0, 64'h0, 4'h0, 1'b0, 64'h0, 2'd0, 64'h0, 1'b0, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 4'h0, 64'h0, 4'h0, 1'b0, 64'h0, 2'd0, 64'h0, 1'b1, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b0, 1'b1, 32'h1008, 1'b1, 64'hDEAD, 4'h0, 64'h0, 4'h0, 1'b1, 64'hDEAD, 2'd0, 64'h0, 1'b0, 1'b0, 7'd0, 22'h0));
        // miss 0x2010, two refused issues, accepted with tag 3
        tv.push_back(mk(1'b0, 1'b1, 32'h2010, 1'b0, 64'h1111, 4'h0, 64'h0, 4'h0, 1'b0, 64'h1111, 2'd0, 64'h0, 1'b0, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b0, 1'b1, 32'h2010, 1'b0, 64'h1111, 4'h0, 64'h0, 4'h0, 1'b0, 64'h1111, 2'd1, 64'h2010, 1'b1, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b0, 1'b1, 32'h2010, 1'b0, 64'h1111, 4'h0, 64'h0, 4'h0, 1'b0, 64'h1111, 2'd1, 64'h2010, 1'b1, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b0, 1'b1, 32'h2010, 1'b0, 64'h1111, 4'h3, 64'h0, 4'h0, 1'b0, 64'h1111, 2'd1, 64'h2010, 1'b1, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b0, 1'b1, 32'h2010, 1'b0, 64'h1111, 4'h0, 64'h0, 4'h0, 1'b0, 64'h1111, 2'd0, 64'h0, 1'b0, 1'b0, 7'd0, 22'h0));
        // wrong tag 5 ignored, tag 3 fills and forwards
        tv.push_back(mk(1'b0, 1'b1, 32'h2010, 1'b0, 64'h1111, 4'h0, 64'h5555, 4'h5, 1'b0, 64'h1111, 2'd0, 64'h0, 1'b0, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b0, 1'b1, 32'h2010, 1'b0, 64'h1111, 4'h0, 64'hBEEF, 4'h3, 1'b1, 64'hBEEF, 2'd0, 64'h0, 1'b0, 1'b1, 7'd2, 22'h8));
        tv.push_back(mk(1'b0, 1'b1, 32'h2010, 1'b1, 64'hBEEF, 4'h0, 64'h0, 4'h0, 1'b1, 64'hBEEF, 2'd0, 64'h0, 1'b0, 1'b0, 7'd0, 22'h0));
        // miss 0x3000 redirected to 0x4000 while in REQ
        tv.push_back(mk(1'b0, 1'b1, 32'h3000, 1'b0, 64'h0, 4'h0, 64'h0, 4'h0, 1'b0, 64'h0, 2'd0, 64'h0, 1'b0, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b0, 1'b1, 32'h4000, 1'b0, 64'h0, 4'h2, 64'h0, 4'h0, 1'b0, 64'h0, 2'd0, 64'h0, 1'b0, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b0, 1'b1, 32'h4000, 1'b0, 64'h0, 4'h0, 64'h0, 4'h0, 1'b0, 64'h0, 2'd0, 64'h0, 1'b0, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b0, 1'b1, 32'h4000, 1'b0, 64'h0, 4'h0, 64'h0, 4'h0, 1'b0, 64'h0, 2'd1, 64'h4000, 1'b1, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b0, 1'b1, 32'h4000, 1'b0, 64'h0, 4'h4, 64'h0, 4'h0, 1'b0, 64'h0, 2'd1, 64'h4000, 1'b1, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b0, 1'b1, 32'h4000, 1'b0, 64'h0, 4'h0, 64'h4444, 4'h4, 1'b1, 64'h4444, 2'd0, 64'h0, 1'b0, 1'b1, 7'd0, 22'h10));
        // miss 0x3000, redirect to 0x5000 during WAIT: fill without forwarding
        tv.push_back(mk(1'b0, 1'b1, 32'h3000, 1'b0, 64'h0, 4'h0, 64'h0, 4'h0, 1'b0, 64'h0, 2'd0, 64'h0, 1'b0, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b0, 1'b1, 32'h3000, 1'b0, 64'h0, 4'h6, 64'h0, 4'h0, 1'b0, 64'h0, 2'd1, 64'h3000, 1'b1, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b0, 1'b1, 32'h5000, 1'b0, 64'h0, 4'h0, 64'h0, 4'h0, 1'b0, 64'h0, 2'd0, 64'h0, 1'b0, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b0, 1'b1, 32'h5000, 1'b0, 64'h7777, 4'h0, 64'h6666, 4'h6, 1'b0, 64'h7777, 2'd0, 64'h0, 1'b0, 1'b1, 7'd0, 22'hC));
        tv.push_back(mk(1'b0, 1'b1, 32'h5000, 1'b0, 64'h0, 4'h0, 64'h0, 4'h0, 1'b0, 64'h0, 2'd0, 64'h0, 1'b0, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b0, 1'b1, 32'h5000, 1'b0, 64'h0, 4'h0, 64'h0, 4'h0, 1'b0, 64'h0, 2'd1, 64'h5000, 1'b1, 1'b0, 7'd0, 22'h0));
        // accepted with tag 7, reset in WAIT, late tag 7 ignored
        tv.push_back(mk(1'b0, 1'b1, 32'h5000, 1'b0, 64'h0, 4'h7, 64'h0, 4'h0, 1'b0, 64'h0, 2'd1, 64'h5000, 1'b1, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b1, 1'b1, 32'h5000, 1'b0, 64'h0, 4'h0, 64'h0, 4'h0, 1'b0, 64'h0, 2'd0, 64'h0, 1'b0, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 4'h0, 64'h7777, 4'h7, 1'b0, 64'h0, 2'd0, 64'h0, 1'b1, 1'b0, 7'd0, 22'h0));
        tv.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 4'h0, 64'h7777, 4'h7, 1'b0, 64'h0, 2'd0, 64'h0, 1'b1, 1'b0, 7'd0, 22'h0));

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clock);
            drive(tv[i].rst, tv[i].req, tv[i].addr, tv[i].cv, tv[i].cd, tv[i].resp, tv[i].md, tv[i].mt);
            #1;
            check_vec(tv[i], $sformatf("vec%0d", i));
        end

        // Reset while in REQ with a response offered; the abandoned tag returns later.
        h = mk(1'b0, 1'b1, 32'h6000, 1'b0, 64'h0, 4'h0, 64'h0, 4'h0, 1'b0, 64'h0, 2'd0, 64'h0, 1'b0, 1'b0, 7'd0, 22'h0);
        @(negedge clock); drive(h.rst, h.req, h.addr, h.cv, h.cd, h.resp, h.md, h.mt); #1; check_vec(h, "rstreq0");
        h = mk(1'b1, 1'b1, 32'h6000, 1'b0, 64'h0, 4'h9, 64'h0, 4'h0, 1'b0, 64'h0, 2'd0, 64'h0, 1'b0, 1'b0, 7'd0, 22'h0);
        @(negedge clock); drive(h.rst, h.req, h.addr, h.cv, h.cd, h.resp, h.md, h.mt); #1; check_vec(h, "rstreq1");
        h = mk(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 4'h0, 64'h9999, 4'h9, 1'b0, 64'h0, 2'd0, 64'h0, 1'b1, 1'b0, 7'd0, 22'h0);
        @(negedge clock); drive(h.rst, h.req, h.addr, h.cv, h.cd, h.resp, h.md, h.mt); #1; check_vec(h, "rstreq2");

        // Bounded wait for the load to 0x7008, then accept with tag 1 and fill.
        found = 1'b0;
        for (int c = 0; c < 4 && !found; c++) begin
            @(negedge clock);
            drive(1'b0, 1'b1, 32'h7008, 1'b0, 64'h0, 4'h0, 64'h0, 4'h0);
            #1;
            if (proc2Imem_command == 2'd1) found = 1'b1;
        end
        n_vec++;
        chk("load_seen", {63'd0, found}, 64'd1);
        chk("load_addr", proc2Imem_addr, 64'h7008);
        h = mk(1'b0, 1'b1, 32'h7008, 1'b0, 64'h0, 4'h1, 64'h0, 4'h0, 1'b0, 64'h0, 2'd1, 64'h7008, 1'b1, 1'b0, 7'd0, 22'h0);
        @(negedge clock); drive(h.rst, h.req, h.addr, h.cv, h.cd, h.resp, h.md, h.mt); #1; check_vec(h, "fill0");
        h = mk(1'b0, 1'b1, 32'h7008, 1'b0, 64'h0, 4'h0, 64'hCAFE, 4'h1, 1'b1, 64'hCAFE, 2'd0, 64'h0, 1'b0, 1'b1, 7'd1, 22'h1C);
        @(negedge clock); drive(h.rst, h.req, h.addr, h.cv, h.cd, h.resp, h.md, h.mt); #1; check_vec(h, "fill1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
